// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD operand sequencer.
// Holds the sequencer state encoding and default datapath width.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    GOT_A,
    START,
    WAIT_DONE,
    SHOW
  } gcd_state_e;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer, stability counter,
// and a one-cycle pulse on each accepted high-to-low transition.
module button_debounce #(
  parameter int CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
        // level was high, so the accepted level is low
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Collects two signed switch operands, hands magnitudes to a GCD
// core, and shows the result (with zero bypass and timeout).
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH           = GCD_WIDTH,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic             CLOCK_125_p,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SW,
  input  logic             load_btn,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic [WIDTH-1:0] LEDR,
  output logic             busy,
  output logic             error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  gcd_state_e       state, state_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] res_q, res_n;
  logic             err_q, err_n;
  logic [TW-1:0]    tcnt_q, tcnt_n;
  logic             press;
  logic [WIDTH-1:0] sw_mag;

  button_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (CLOCK_125_p),
    .rst_n(rst_n),
    .btn  (load_btn),
    .press(press)
  );

  assign sw_mag = SW[WIDTH-1] ? (~SW + 1'b1) : SW;

  always_ff @(posedge CLOCK_125_p) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      tcnt_q <= '0;
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      b_q    <= b_n;
      res_q  <= res_n;
      err_q  <= err_n;
      tcnt_q <= tcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    res_n   = res_q;
    err_n   = err_q;
    tcnt_n  = tcnt_q;
    unique case (state)
      IDLE: begin
        if (press) begin
          a_n     = sw_mag;
          state_n = GOT_A;
        end
      end
      GOT_A: begin
        if (press) begin
          b_n = sw_mag;
          if (a_q == '0 || sw_mag == '0) begin
            // one side is zero, so OR yields the other
            res_n   = a_q | sw_mag;
            err_n   = (a_q == '0) && (sw_mag == '0);
            state_n = SHOW;
          end else begin
            state_n = START;
          end
        end
      end
      START: begin
        tcnt_n  = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done) begin
          res_n   = core_result;
          err_n   = 1'b0;
          state_n = SHOW;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_n   = '1;
          err_n   = 1'b1;
          state_n = SHOW;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (press) begin
          a_n     = sw_mag;
          err_n   = 1'b0;
          state_n = GOT_A;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    LEDR = '0;
    unique case (state)
      GOT_A:   LEDR = a_q;
      SHOW:    LEDR = res_q;
      default: LEDR = '0;
    endcase
  end

  assign core_start = (state == START);
  assign busy       = (state == START) || (state == WAIT_DONE);
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign error      = err_q;

endmodule
